// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers fetched bytes into ir, and handles redirect, HALT and fetch counting.
// Optional FETCH_BOUND_CHECK_EN adds a FAULT state for PCs at or beyond MEM_DEPTH; otherwise addresses wrap modulo MEM_DEPTH.
module fetch_sequencer #(
    parameter int                 ADDR_W      = 8,
    parameter int                 INSN_W      = 8,
    parameter int                 MEM_DEPTH   = 32,
    parameter logic [INSN_W-1:0]  HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    output logic [INSN_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
`ifdef FETCH_BOUND_CHECK_EN
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
`else
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_DEPTH - 1);
`endif

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_inc_s;
    logic [INSN_W-1:0]   ir_r;
    logic [ADDR_W-1:0]   ir_pc_r;
    logic                ir_valid_r;
    logic [15:0]         fetch_count_r;
    logic                restart_s;
    logic                is_halt_s;
    logic                oob_inc_s;
    logic                oob_redir_s;
    logic                halted_s;
    logic                fault_s;

    // Derived per-cycle conditions: next PC, restart request, opcode and range tests.
    always_comb begin
        pc_inc_s  = pc_r + PC_ONE;
        restart_s = start && (state_r != ST_RUN);
        is_halt_s = (imem_data == HALT_OPCODE);
`ifdef FETCH_BOUND_CHECK_EN
        oob_inc_s   = ({1'b0, pc_inc_s}    >= DEPTH_EXT);
        oob_redir_s = ({1'b0, redirect_pc} >= DEPTH_EXT);
        imem_addr   = pc_r;
`else
        oob_inc_s   = 1'b0;
        oob_redir_s = 1'b0;
        imem_addr   = pc_r & ADDR_MASK;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; redirect outranks stall and HALT detection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    if (oob_redir_s) state_next_s = ST_FAULT;
                    else             state_next_s = ST_RUN;
                end else if (stall) begin
                    state_next_s = ST_RUN;
                end else if (is_halt_s) begin
                    state_next_s = ST_HALT;
                end else if (oob_inc_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT, ST_FAULT: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the registered state.
    always_comb begin
        halted_s = 1'b0;
        fault_s  = 1'b0;
        case (state_r)
            ST_HALT: begin
                halted_s = 1'b1;
            end
            ST_FAULT: begin
                halted_s = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
                fault_s  = 1'b1;
`else
                fault_s  = 1'b0;
`endif
            end
            default: begin
                halted_s = 1'b0;
                fault_s  = 1'b0;
            end
        endcase
    end

    // Datapath: PC, instruction register and saturating fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= {ADDR_W{1'b0}};
            ir_r          <= {INSN_W{1'b0}};
            ir_pc_r       <= {ADDR_W{1'b0}};
            ir_valid_r    <= 1'b0;
            fetch_count_r <= 16'h0000;
        end else if (restart_s) begin
            pc_r          <= {ADDR_W{1'b0}};
            ir_valid_r    <= 1'b0;
            fetch_count_r <= 16'h0000;
        end else if (state_r == ST_RUN) begin
            if (redirect_valid) begin
                pc_r       <= redirect_pc;
                ir_valid_r <= 1'b0;
            end else if (stall) begin
                ir_valid_r <= 1'b0;
            end else begin
                ir_r       <= imem_data;
                ir_pc_r    <= pc_r;
                ir_valid_r <= 1'b1;
                pc_r       <= pc_inc_s;
                if (fetch_count_r != 16'hFFFF) begin
                    fetch_count_r <= fetch_count_r + 16'h0001;
                end
            end
        end else begin
            ir_valid_r <= 1'b0;
        end
    end

    assign ir          = ir_r;
    assign ir_pc       = ir_pc_r;
    assign ir_valid    = ir_valid_r;
    assign halted      = halted_s;
    assign fault       = fault_s;
    assign fetch_count = fetch_count_r;

endmodule
